// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ECG ADC sample stream: sample widths,
// default filter window and the boxcar output-register state type.
package adc_stream_pkg;

  localparam int ADC_BITS          = 12;
  localparam int SAMPLE_W          = 16;
  localparam int DEFAULT_LOG2_TAPS = 3;

  // Output register state: EMPTY holds nothing, HOLD presents a result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ma_state_e;

  // Accumulator width for a window of 2^log2_taps samples of data_w bits.
  function automatic int sum_width(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// Circular N-entry sample store for the moving average. The entry under
// the write pointer is always the oldest sample, read combinationally so
// the accumulator can subtract it in the same cycle it is overwritten.
module ma_delay_line #(
  parameter int DATA_W    = 16,
  parameter int LOG2_TAPS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] old_data
);

  localparam int N = 1 << LOG2_TAPS;

  logic [DATA_W-1:0]    line [N];
  logic [LOG2_TAPS-1:0] wptr;

  assign old_data = line[wptr];

  // Overwrite the oldest entry and advance; N is a power of two so the
  // pointer wraps N-1 -> 0 by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        line[i] <= '0;
      end
      wptr <= '0;
    end else if (wr_en) begin
      line[wptr] <= wr_data;
      wptr       <= wptr + 1'b1;
    end
  end

endmodule

// File: rtl/axis_moving_avg.sv
// Boxcar low-pass filter on an AXI4-Stream sample stream. Keeps a running
// sum of the last 2^LOG2_TAPS samples and emits sum >> LOG2_TAPS through a
// single output register with pass-through ready.
module axis_moving_avg
  import adc_stream_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int LOG2_TAPS = DEFAULT_LOG2_TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              filled
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_TAPS);

  // Mean of the window, truncating toward zero.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_TAPS];
  endfunction

  ma_state_e            state_p1;
  logic [SUM_W-1:0]     sum_p1;
  logic [DATA_W-1:0]    tdata_p1;
  logic [LOG2_TAPS-1:0] fill_cnt;
  logic                 filled_p1;

  logic [DATA_W-1:0]    old_data;
  logic [SUM_W-1:0]     sum_next;
  logic                 accept;
  logic                 out_hs;

  assign m_axis_tvalid = (state_p1 == ST_HOLD);
  assign m_axis_tdata  = tdata_p1;
  assign filled        = filled_p1;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  // The sum always equals N in-range samples, so this never wraps.
  assign sum_next = sum_p1 + {{LOG2_TAPS{1'b0}}, s_axis_tdata}
                           - {{LOG2_TAPS{1'b0}}, old_data};

  ma_delay_line #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_data  (s_axis_tdata),
    .old_data (old_data)
  );

  // ---- stage p1: accumulator and output data register ----
  // Update the running sum and the presented average on each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1   <= '0;
      tdata_p1 <= '0;
    end else if (accept) begin
      sum_p1   <= sum_next;
      tdata_p1 <= avg_trunc(sum_next);
    end
  end

  // Output valid: load on accept, drop on a handshake with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= ST_EMPTY;
    end else begin
      case (state_p1)
        ST_EMPTY: if (accept) state_p1 <= ST_HOLD;
        ST_HOLD:  if (out_hs && !accept) state_p1 <= ST_EMPTY;
        default:  state_p1 <= ST_EMPTY;
      endcase
    end
  end

  // Count accepts until the window is primed, then latch filled until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      filled_p1 <= 1'b0;
    end else if (accept && !filled_p1) begin
      if (fill_cnt == '1) begin
        filled_p1 <= 1'b1;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_moving_avg.sv
// Directed bench for axis_moving_avg: a table of per-cycle vectors plus
// hand-written sequences for backpressure, mid-window reset, streaming
// and an ADC-like source.
module tb_axis_moving_avg;
  import adc_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        filled;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axis_moving_avg #(.DATA_W(16), .LOG2_TAPS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .filled        (filled)
  );

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        exp_sready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_filled;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic v, input int d, input logic r, input logic esr,
                     input logic ev, input int ed, input logic ef);
    vec_t x;
    x.in_valid = v; x.in_data = 16'(d); x.out_ready = r;
    x.exp_sready = esr; x.exp_valid = ev; x.exp_data = 16'(ed); x.exp_filled = ef;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata",  int'(m_axis_tdata), 0);
    chk("rst_filled", int'(filled), 0);
    chk("rst_sready", int'(s_axis_tready), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive at negedge, check ready before the edge, outputs after.
  task automatic step(input logic v, input logic [15:0] d, input logic r,
                      input string tag, input logic esr, input logic ev,
                      input logic [15:0] ed, input logic ef);
    @(negedge clk);
    s_axis_tvalid = v; s_axis_tdata = d; m_axis_tready = r;
    #1;
    chk({tag, "_sready"}, int'(s_axis_tready), int'(esr));
    @(posedge clk);
    #1;
    chk({tag, "_tvalid"}, int'(m_axis_tvalid), int'(ev));
    chk({tag, "_tdata"},  int'(m_axis_tdata),  int'(ed));
    chk({tag, "_filled"}, int'(filled),        int'(ef));
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready,
           $sformatf("vec%0d", i), vecs[i].exp_sready, vecs[i].exp_valid,
           vecs[i].exp_data, vecs[i].exp_filled);
    end
    vecs.delete();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    logic [15:0] win [8];
    int          wsum;
    int          exp_avg;
    int          nsent;
    int          nrecv;
    logic [15:0] samp;

    rst_n = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    do_reset();

    // Constant 800: ramp 100..800, filled on the 8th, 9th stays 800, then drain.
    for (int k = 1; k <= 8; k++) add(1, 800, 1, 1, 1, 100 * k, k == 8);
    add(1, 800, 1, 1, 1, 800, 1);
    add(0, 0,   1, 1, 0, 800, 1);
    run_table();

    // Max-value stress: 0x0FFF ramp, 0xFFFF up to full scale, zeros back down.
    do_reset();
    for (int k = 1; k <= 8; k++) add(1, 16'h0FFF, 1, 1, 1, (k * 4095) >> 3, k == 8);
    for (int j = 1; j <= 8; j++) add(1, 16'hFFFF, 1, 1, 1, ((8 - j) * 4095 + j * 65535) >> 3, 1);
    for (int j = 1; j <= 8; j++) add(1, 16'h0000, 1, 1, 1, ((8 - j) * 65535) >> 3, 1);
    run_table();

    // Backpressure: one result held 20 clocks, a sample offered meanwhile is dropped.
    do_reset();
    step(1, 16'd100, 1, "bp_first", 1, 1, 16'd12, 0);
    for (int c = 0; c < 20; c++) begin
      step(c == 10, 16'd900, 0, $sformatf("bp_hold%0d", c), 0, 1, 16'd12, 0);
    end
    step(0, 16'd0, 1, "bp_release", 1, 0, 16'd12, 0);
    step(1, 16'd100, 1, "bp_next", 1, 1, 16'd25, 0);

    // Back-to-back stream 8,16,24,... against a window model.
    do_reset();
    for (int i = 0; i < 8; i++) win[i] = '0;
    for (int i = 0; i < 12; i++) begin
      win[i % 8] = 16'(8 * (i + 1));
      wsum = 0;
      for (int j = 0; j < 8; j++) wsum += int'(win[j]);
      step(1, 16'(8 * (i + 1)), 1, $sformatf("b2b%0d", i), 1, 1, 16'(wsum >> 3), i >= 7);
    end

    // Mid-window asynchronous reset clears everything immediately.
    do_reset();
    for (int k = 1; k <= 5; k++) step(1, 16'd400, 1, $sformatf("mid%0d", k), 1, 1, 16'(50 * k), 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", int'(m_axis_tvalid), 0);
    chk("mid_rst_tdata",  int'(m_axis_tdata), 0);
    chk("mid_rst_filled", int'(filled), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'd400, 1, "mid_after", 1, 1, 16'd50, 0);

    // ADC-like source: one-cycle tvalid pulses of 12-bit samples every 7 clocks.
    do_reset();
    for (int i = 0; i < 8; i++) win[i] = '0;
    nsent = 0; nrecv = 0;
    for (int i = 0; i < 24; i++) begin
      samp = 16'($urandom_range(0, (1 << ADC_BITS) - 1));
      win[i % 8] = samp;
      wsum = 0;
      for (int j = 0; j < 8; j++) wsum += int'(win[j]);
      exp_avg = wsum >> 3;
      @(negedge clk);
      s_axis_tvalid = 1'b1; s_axis_tdata = samp;
      nsent++;
      @(posedge clk);
      #1;
      if (m_axis_tvalid) nrecv++;
      chk($sformatf("adc%0d_tdata", i), int'(m_axis_tdata), exp_avg);
      @(negedge clk);
      s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      repeat (5) @(negedge clk);
    end
    chk("adc_count", nrecv, nsent);
    chk("adc_filled", int'(filled), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
